// File: rtl/mmu_pkg.sv
// Shared constants, region type and load-extension helper
// for the RV32I softcore memory-management block.
package mmu_pkg;

  localparam logic [31:0] DRAM_BASE = 32'h1000_0000;
  localparam logic [31:0] IO_BASE   = 32'h8000_0000;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_IO
  } region_e;

  function automatic logic [31:0] ext8(
    input logic [7:0] v,
    input logic       sgn
  );
    return {{24{sgn & v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(
    input logic [15:0] v,
    input logic        sgn
  );
    return {{16{sgn & v[15]}}, v};
  endfunction

endpackage

// File: rtl/mmu_dram.sv
// Byte-enabled synchronous single-port data RAM.
// Read port only updates when re is high so the output holds.
module mmu_dram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mmu.sv
// Bus decode, lane steering and load extension between the
// core fetch/data ports, the instruction ROM, data RAM and IO.
module mmu
  import mmu_pkg::*;
#(
  parameter int          DRAM_AW   = 10,
  parameter logic [31:0] DRAM_BASE = mmu_pkg::DRAM_BASE,
  parameter logic [31:0] IO_BASE   = mmu_pkg::IO_BASE
) (
  input  logic        clk_i,
  input  logic        resetb,
  input  logic [31:0] im_addr,
  output logic [31:0] im_do,
  output logic [11:0] im_rom_addr,
  input  logic [31:0] im_rom_data,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_be,
  input  logic        is_signed,
  input  logic [31:0] dm_di,
  output logic [31:0] dm_do,
  output logic [7:0]  io_addr,
  output logic        io_en,
  output logic        io_we,
  output logic [31:0] io_data_write,
  input  logic [31:0] io_data_read
);

  localparam int RAM_LSB = DRAM_AW + 2;

  assign im_rom_addr = im_addr[13:2];
  assign im_do       = im_rom_data;

  logic unused_ok;
  assign unused_ok = ^{im_addr[31:14], im_addr[1:0],
                       dm_addr[1:0]};

  logic    ram_hit;
  logic    io_hit;
  region_e region;

  assign ram_hit =
    dm_addr[31:RAM_LSB] == DRAM_BASE[31:RAM_LSB];
  assign io_hit = dm_addr[31:10] == IO_BASE[31:10];

  always_comb begin
    region = REG_NONE;
    if (ram_hit)     region = REG_RAM;
    else if (io_hit) region = REG_IO;
  end

  logic is_byte;
  logic is_half;
  logic [31:0] wdata;

  assign is_byte = dm_be inside {BE_B0, BE_B1, BE_B2, BE_B3};
  assign is_half = dm_be inside {BE_H0, BE_H1};

  always_comb begin
    wdata = dm_di;
    unique case (1'b1)
      is_byte: wdata = {4{dm_di[7:0]}};
      is_half: wdata = {2{dm_di[15:0]}};
      default: wdata = dm_di;
    endcase
  end

  logic        ram_re;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  assign ram_re = en & ~we & (region == REG_RAM);
  assign ram_we = {4{en & we & (region == REG_RAM)}} & dm_be;

  mmu_dram #(
    .AW (DRAM_AW)
  ) u_dram (
    .clk   (clk_i),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (dm_addr[RAM_LSB-1:2]),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  assign io_addr       = dm_addr[9:2];
  assign io_en         = resetb & en & (region == REG_IO);
  assign io_we         = io_en & we;
  assign io_data_write = wdata;

  region_e     region_q;
  logic [3:0]  be_q;
  logic        sgn_q;
  logic [31:0] io_q;

  always_ff @(posedge clk_i or negedge resetb) begin
    if (!resetb) begin
      region_q <= REG_NONE;
      be_q     <= 4'b0000;
      sgn_q    <= 1'b0;
      io_q     <= 32'd0;
    end else if (en && !we) begin
      region_q <= region;
      be_q     <= dm_be;
      sgn_q    <= is_signed;
      if (region == REG_IO) io_q <= io_data_read;
    end
  end

  logic [31:0] word_q;

  always_comb begin
    word_q = 32'd0;
    unique case (region_q)
      REG_RAM: word_q = ram_rdata;
      REG_IO:  word_q = io_q;
      default: word_q = 32'd0;
    endcase
  end

  // Illegal non-zero masks return the raw word.
  always_comb begin
    dm_do = word_q;
    unique case (be_q)
      4'b0000: dm_do = 32'd0;
      BE_B0:   dm_do = ext8(word_q[7:0], sgn_q);
      BE_B1:   dm_do = ext8(word_q[15:8], sgn_q);
      BE_B2:   dm_do = ext8(word_q[23:16], sgn_q);
      BE_B3:   dm_do = ext8(word_q[31:24], sgn_q);
      BE_H0:   dm_do = ext16(word_q[15:0], sgn_q);
      BE_H1:   dm_do = ext16(word_q[31:16], sgn_q);
      default: dm_do = word_q;
    endcase
  end

endmodule

// File: tb/tb_mmu.sv
// Randomized and directed bench for mmu against a
// byte-array memory model.
module tb_mmu;

  logic        clk_i = 1'b0;
  logic        resetb;
  logic [31:0] im_addr;
  logic [31:0] im_do;
  logic [11:0] im_rom_addr;
  logic [31:0] im_rom_data;
  logic        en;
  logic        we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic        is_signed;
  logic [31:0] dm_di;
  logic [31:0] dm_do;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;

  int checks = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  assign im_rom_data  = 32'd4095 - {20'd0, im_rom_addr};
  assign io_data_read = 32'd4096 + {24'd0, io_addr};

  mmu dut (
    .clk_i         (clk_i),
    .resetb        (resetb),
    .im_addr       (im_addr),
    .im_do         (im_do),
    .im_rom_addr   (im_rom_addr),
    .im_rom_data   (im_rom_data),
    .en            (en),
    .we            (we),
    .dm_addr       (dm_addr),
    .dm_be         (dm_be),
    .is_signed     (is_signed),
    .dm_di         (dm_di),
    .dm_do         (dm_do),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read)
  );

  logic [7:0] ram_m [4096];

  logic        io_en_s;
  logic        io_we_s;
  logic [7:0]  io_addr_s;
  logic [31:0] io_wd_s;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a[31:12] == 20'h10000;
  endfunction

  function automatic bit is_io(input logic [31:0] a);
    return a[31:10] == 22'h200000;
  endfunction

  function automatic int ones(input logic [3:0] be);
    return int'(be[0]) + int'(be[1]) + int'(be[2]) + int'(be[3]);
  endfunction

  function automatic bit half_mask(input logic [3:0] be);
    return be == 4'd3 || be == 4'd12;
  endfunction

  // Byte that lands in lane b for a given store.
  function automatic logic [7:0] lane_byte(input int b,
                                           input logic [3:0] be,
                                           input logic [31:0] d);
    if (ones(be) == 1) return d[7:0];
    if (half_mask(be)) return d[8*(b%2) +: 8];
    return d[8*b +: 8];
  endfunction

  function automatic logic [31:0] steer(input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = lane_byte(b, be, d);
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a,
                                           input logic [3:0] be,
                                           input logic sg);
    logic [31:0] w;
    longint v;
    int lane;
    int base;
    if (be == 4'd0) return 32'd0;
    base = int'(a[11:2]) * 4;
    if (is_ram(a))
      w = {ram_m[base+3], ram_m[base+2], ram_m[base+1], ram_m[base]};
    else if (is_io(a)) w = 32'd4096 + 32'(a[9:2]);
    else w = 32'd0;
    if (ones(be) == 1) begin
      lane = be[0] ? 0 : be[1] ? 1 : be[2] ? 2 : 3;
      v = (w >> (8*lane)) & 32'hFF;
      if (sg && v >= 128) v = v - 256;
      return 32'(v);
    end
    if (half_mask(be)) begin
      lane = be[0] ? 0 : 2;
      v = (w >> (8*lane)) & 32'hFFFF;
      if (sg && v >= 32768) v = v - 65536;
      return 32'(v);
    end
    return w;
  endfunction

  task automatic acc(input logic w, input logic [31:0] a,
                     input logic [3:0] be, input logic sg,
                     input logic [31:0] d);
    @(negedge clk_i);
    en = 1'b1; we = w; dm_addr = a;
    dm_be = be; is_signed = sg; dm_di = d;
    #1;
    io_en_s = io_en; io_we_s = io_we;
    io_addr_s = io_addr; io_wd_s = io_data_write;
    @(posedge clk_i);
    #1;
    en = 1'b0; we = 1'b0;
    if (w && is_ram(a))
      for (int b = 0; b < 4; b++)
        if (be[b]) ram_m[int'(a[11:2])*4 + b] = lane_byte(b, be, d);
  endtask

  logic [3:0] masks [8] = '{4'h1, 4'h2, 4'h4, 4'h8,
                            4'h3, 4'hC, 4'hF, 4'h0};

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] hold;
    logic [3:0]  be;
    logic        w;
    logic        sg;
    int          r;

    resetb = 1'b0; en = 1'b0; we = 1'b0;
    dm_addr = 32'd0; dm_be = 4'd0; is_signed = 1'b0;
    dm_di = 32'd0; im_addr = 32'd0;
    #12;
    chk("reset_dm_do", dm_do, 32'd0);
    chk("reset_io_en", {31'd0, io_en}, 32'd0);
    @(negedge clk_i);
    resetb = 1'b1;

    im_addr = 32'h0000_0010;
    #1;
    chk("im_rom_addr", {20'd0, im_rom_addr}, 32'd4);
    chk("im_do", im_do, 32'd4091);

    for (int i = 0; i < 1024; i++)
      acc(1'b1, 32'h1000_0000 + 32'(i*4), 4'hF, 1'b0, $urandom);

    for (int i = 0; i < 40; i++) begin
      a = 32'h1000_0000 + 32'(4*i);
      for (int l = 0; l < 4; l++) acc(1'b1, a, 4'(1 << l), 1'b0, 32'(i));
      for (int l = 0; l < 4; l++) begin
        acc(1'b0, a, 4'(1 << l), 1'b0, 32'd0);
        chk("byte_ld", dm_do, 32'(i));
      end
    end

    acc(1'b1, 32'h1000_0010, 4'hC, 1'b0, 32'h0000_BEEF);
    acc(1'b0, 32'h1000_0010, 4'hC, 1'b0, 32'd0);
    chk("half_u", dm_do, 32'h0000_BEEF);
    acc(1'b0, 32'h1000_0010, 4'hC, 1'b1, 32'd0);
    chk("half_s", dm_do, 32'hFFFF_BEEF);
    hold = dm_do;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("hold", dm_do, hold);

    acc(1'b1, 32'h1000_0020, 4'hF, 1'b0, 32'h1234_5678);
    acc(1'b0, 32'h1000_0020, 4'h4, 1'b0, 32'd0);
    chk("word_b2", dm_do, 32'h34);

    acc(1'b1, 32'h1000_0030, 4'h1, 1'b0, 32'h80);
    acc(1'b0, 32'h1000_0030, 4'h1, 1'b1, 32'd0);
    chk("sext_b", dm_do, 32'hFFFF_FF80);
    acc(1'b0, 32'h1000_0030, 4'h1, 1'b0, 32'd0);
    chk("zext_b", dm_do, 32'h80);

    acc(1'b0, 32'h8000_0014, 4'hF, 1'b0, 32'd0);
    chk("io_ld_addr", {24'd0, io_addr_s}, 32'd5);
    chk("io_ld_en", {31'd0, io_en_s}, 32'd1);
    chk("io_ld_we", {31'd0, io_we_s}, 32'd0);
    chk("io_ld_do", dm_do, 32'd4101);

    acc(1'b1, 32'h8000_0008, 4'h2, 1'b0, 32'hAB);
    chk("io_st_we", {31'd0, io_we_s}, 32'd1);
    chk("io_st_data", io_wd_s, 32'hABAB_ABAB);

    acc(1'b0, 32'h2000_0000, 4'hF, 1'b0, 32'd0);
    chk("unmap_ld", dm_do, 32'd0);
    acc(1'b1, 32'h2000_0000, 4'hF, 1'b0, 32'hDEAD_BEEF);
    chk("unmap_io_en", {31'd0, io_en_s}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000_0000 + 32'(4*i);
      acc(1'b0, a, 4'hF, 1'b0, 32'd0);
      chk("unmap_st", dm_do, exp_load(a, 4'hF, 1'b0));
    end

    acc(1'b0, 32'h1000_0020, 4'hF, 1'b0, 32'd0);
    chk("pre_rst", dm_do, 32'h1234_5678);
    @(negedge clk_i);
    en = 1'b1; we = 1'b0; dm_addr = 32'h8000_0004; dm_be = 4'hF;
    #2;
    resetb = 1'b0;
    #1;
    chk("rst_dm_do", dm_do, 32'd0);
    chk("rst_io_en", {31'd0, io_en}, 32'd0);
    @(posedge clk_i);
    #1;
    chk("rst_hold", dm_do, 32'd0);
    en = 1'b0;
    @(negedge clk_i);
    resetb = 1'b1;
    acc(1'b0, 32'h1000_0020, 4'hF, 1'b0, 32'd0);
    chk("ram_kept", dm_do, 32'h1234_5678);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'h1000_0000 | ($urandom & 32'hFFC);
      else if (r < 9) a = 32'h8000_0000 | ($urandom & 32'h3FC);
      else            a = 32'h2000_0000 | ($urandom & 32'hFFFC);
      be = ($urandom_range(0, 9) == 0) ? 4'($urandom)
                                       : masks[$urandom_range(0, 7)];
      w  = 1'($urandom);
      sg = 1'($urandom);
      d  = $urandom;
      e  = exp_load(a, be, sg);
      hold = dm_do;
      acc(w, a, be, sg, d);
      if (!w) chk("rnd_ld", dm_do, e);
      else chk("rnd_st_hold", dm_do, hold);
      if (is_io(a)) begin
        chk("rnd_io_en", {31'd0, io_en_s}, 32'd1);
        chk("rnd_io_we", {31'd0, io_we_s}, {31'd0, w});
        chk("rnd_io_addr", {24'd0, io_addr_s}, {24'd0, a[9:2]});
        if (w) chk("rnd_io_wd", io_wd_s, steer(be, d));
      end else begin
        chk("rnd_no_io", {31'd0, io_en_s}, 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mmu.md
Name: mmu

Overview:
- Memory-management/bus-decode block for the embedded RV32I softcore.
- Sits between the core's instruction-fetch and data ports and the memories:
  - forwards instruction fetches to an external 4096-word instruction ROM;
  - holds an internal byte-addressable data RAM;
  - bridges a 256-word memory-mapped IO bus.
- Performs byte/half/word lane steering and load sign/zero extension.

Parameters:
- DRAM_AW, 10, data RAM word-address width (2^DRAM_AW 32-bit words, 4 KiB default).
- DRAM_BASE, 32'h1000_0000, data RAM base address.
- IO_BASE, 32'h8000_0000, IO region base address (256 words, 1 KiB).

Ports:
- clk_i  in  1  system clock, all state on rising edge.
- resetb  in  1  asynchronous active-low reset.
- im_addr  in  32  core instruction fetch byte address.
- im_do  out  32  instruction to core.
- im_rom_addr  out  12  word address to external instruction ROM.
- im_rom_data  in  32  data from external instruction ROM.
- en  in  1  data access request this cycle.
- we  in  1  1 = store, 0 = load (qualified by en).
- dm_addr  in  32  data byte address (bits [1:0] ignored; dm_be selects lanes).
- dm_be  in  4  byte-lane mask.
- is_signed  in  1  load sign-extend (1) or zero-extend (0).
- dm_di  in  32  store data, LSB-aligned.
- dm_do  out  32  load result, LSB-aligned and extended.
- io_addr  out  8  IO word address = dm_addr[9:2].
- io_en  out  1  IO access strobe.
- io_we  out  1  IO write strobe.
- io_data_write  out  32  lane-positioned IO store data.
- io_data_read  in  32  IO read data, sampled at clock edge.

Behaviour:
- Instruction path, purely combinational:
  - im_rom_addr = im_addr[13:2].
  - im_do = im_rom_data.
  - No decode and no latency added by the MMU.
- Data address decode:
  - RAM when dm_addr[31:DRAM_AW+2] equals DRAM_BASE's upper bits.
  - IO when dm_addr[31:10] equals IO_BASE[31:10].
  - Anything else is unmapped.
- Lane masks:
  - Legal masks: 0001, 0010, 0100, 1000 (byte); 0011, 1100 (half); 1111 (word).
  - 0000 means no access (no write, dm_do = 0 on the next cycle).
  - Any other mask: stores use the raw mask; loads return the full word unextended.
- Store lane steering, applied to both RAM and IO:
  - byte: dm_di[7:0] is replicated to all four lanes.
  - half: dm_di[15:0] is replicated to both halves.
  - word: dm_di is passed unchanged.
- RAM store: on the rising edge with en & we & RAM hit, write only the bytes whose dm_be bit is set.
- IO store (combinational):
  - io_en = en & IO hit.
  - io_we = io_en & we.
  - io_data_write = steered data.
  - The external IO device captures the write on the same edge.
- Loads:
  - Synchronous, 1-cycle latency. The address, mask and is_signed presented with en & ~we in cycle N produce dm_do in cycle N+1.
  - Capture at the edge: RAM word (read-before-write semantics irrelevant since ~we), or io_data_read for an IO hit, or 0 if unmapped.
  - Also capture dm_be and is_signed.
  - dm_do is derived from the registered word and mask: the selected lane is shifted down to bit 0, then sign- or zero-extended from bit 7 (byte) or bit 15 (half).
  - dm_do holds its value until the next load completes.
  - A cycle without en leaves dm_do unchanged.
- Stores to unmapped addresses are dropped; no error signal.
- Reset (resetb low, asynchronous):
  - Load capture registers clear, so dm_do = 0.
  - RAM contents are not cleared.
  - io_en and io_we are driven 0 while resetb is low.
  - An access in flight during reset is lost.
- Simultaneous fetch and data access never conflict: separate ports.

Decomposition:
- Shared package holds:
  - DRAM_BASE and IO_BASE;
  - mask constants BE_B0..BE_B3, BE_H0, BE_H1, BE_W;
  - region enum {REG_NONE, REG_RAM, REG_IO}.
- One sub-module, mmu_dram: byte-enabled synchronous single-port 2^DRAM_AW x 32 RAM.
- Steering, extension and decode stay in mmu.

Test Plan:
- Byte store/load:
  - Stimulus: for i = 0..39, store byte i to 0x1000_0000 + 4i with each mask 0001, 0010, 0100, 1000 (is_signed = 0); then load each lane.
  - Response: every load returns i, one cycle after issue.
- Half and word stores:
  - Stimulus: store 0xBEEF with mask 1100 at 0x1000_0010, then load.
  - Response: dm_do = 0x0000_BEEF unsigned, 0xFFFF_BEEF signed.
  - Stimulus: store word 0x1234_5678, then byte-load lane 2.
  - Response: dm_do = 0x34.
- Sign extension:
  - Stimulus: store 0x80 to lane 0, load with is_signed = 1.
  - Response: dm_do = 0xFFFF_FF80.
  - Stimulus: same load with is_signed = 0.
  - Response: dm_do = 0x80.
- IO:
  - Stimulus: load from 0x8000_0014 with the IO model returning 4096 + index.
  - Response: io_addr = 5, io_en = 1, io_we = 0, dm_do = 4101 the next cycle.
  - Stimulus: store byte 0xAB to 0x8000_0008 mask 0010.
  - Response: io_we = 1, io_data_write = 0xABAB_ABAB.
- Instruction path:
  - Stimulus: im_addr = 0x0000_0010 with the ROM model returning 4095 - index.
  - Response: im_rom_addr = 4, im_do = 4091 combinationally.
- Reset and unmapped:
  - Stimulus: assert resetb mid-load.
  - Response: dm_do = 0 immediately.
  - Stimulus: load from 0x2000_0000.
  - Response: dm_do = 0.
  - Stimulus: store to 0x2000_0000.
  - Response: RAM unchanged.
